fir_sse_stream: RTL and testbench
=================================

Name: fir_sse_stream

Overview:
- Parametrised streaming FIR filter with a built-in sum-of-squared-error (SSE) checker against a golden sample stream.
- Successor to the fixed-width FIR/SSE test harness. Adds parametrised width and tap count, loadable coefficients, a valid/ready input handshake, saturation, and a running sample count.
- Sits between the stimulus source and the result scoreboard in filter-verification datapaths.

Parameters:
- DW, 32, sample, coefficient and golden width (signed two's complement)
- TAPS, 8, number of FIR taps (≥2)
- FRAC, 0, right arithmetic shift applied to the accumulator before output (fixed-point scaling)
- ACC_W, 64, SSE accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index
- coef_data  in  DW  coefficient value
- start  in  1  begin run: clear history/SSE/count
- stop  in  1  end run after the current sample
- in_valid  in  1  in_data/gold_data valid
- in_ready  out  1  block can accept a sample
- in_data  in  DW  filter input sample
- gold_data  in  DW  golden output for this sample
- out_valid  out  1  one-cycle result strobe
- out_filt  out  DW  filtered sample (saturated)
- out_sse  out  ACC_W  running SSE including this sample
- sse_sat  out  1  sticky: SSE saturated
- sample_cnt  out  32  samples completed this run
- busy  out  1  state is MAC or EVAL
- done  out  1  run finished (sticky until start)

Behaviour:
- Reset (rst_n low, async): state IDLE, every output 0, coefficients 0, delay line 0, accumulators 0.
- States: IDLE, RUN, MAC, EVAL, DONE.
- IDLE/DONE:
  - in_ready=0.
  - coef_we writes coef[coef_addr]<=coef_data; out-of-range address ignored.
  - start → RUN; clears delay line, out_sse, sse_sat, sample_cnt and done.
- Coefficient writes in RUN/MAC/EVAL are ignored.
- start while in RUN/MAC/EVAL is ignored.
- RUN:
  - in_ready=1.
  - On in_valid&&in_ready: shift in_data into x[0] (x[k]<=x[k-1]), latch gold_data, acc<=0, k<=0, → MAC.
  - stop with no accept in the same cycle → DONE.
  - stop and accept in the same cycle: the accept wins; stop is remembered and the run ends after that sample.
- MAC (TAPS cycles):
  - acc <= acc + coef[k]*x[k], k++.
  - After k==TAPS-1 → EVAL.
  - acc width is 2*DW+$clog2(TAPS); full precision, no wrap.
- EVAL (1 cycle):
  - y = acc>>>FRAC, saturated to the signed DW range → out_filt.
  - e = y - gold (DW+1 bits signed); e² is unsigned.
  - out_sse <= out_sse + e², saturating at 2^ACC_W-1. On saturation, sse_sat<=1 (sticky).
  - sample_cnt++ (wraps at 2^32).
  - out_valid<=1 for exactly one cycle.
  - Next state: DONE if a stop was seen since the accept, else RUN.
- Latency and throughput:
  - Accept edge E0 → out_valid high after edge E(TAPS+1).
  - Throughput: 1 sample per TAPS+2 cycles.
  - in_ready is 0 throughout MAC/EVAL.
- out_filt/out_sse hold their values between strobes.
- busy=1 in MAC and EVAL.
- done is set on entry to DONE and cleared by start.
- rst_n asserted mid-operation:
  - Immediate return to reset values.
  - Any partial sample is discarded; no out_valid.

Optional Feature:
- Macro: FIR_SSE_MAX_ERR_EN.
- Defined:
  - Extra output port max_abs_err (DW+1 bits, unsigned) = peak |e| this run.
  - Updated in EVAL; cleared by start and by reset.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
1. TAPS=4, FRAC=0, coef={1,0,0,0}, in=gold=5,-3,7 → out_filt 5,-3,7; out_sse 0,0,0; sample_cnt 3; out_valid TAPS+1 cycles after each accept.
2. coef all 1, in 1,2,3,4,5, gold 0 → out_filt 1,3,6,10,14; out_sse 1,10,46,146,342.
3. stop asserted during MAC of the 2nd sample → that sample's out_valid still fires, then DONE; done=1; in_ready=0; start clears out_sse and sample_cnt to 0.
4. ACC_W=16, coef={1,0,0,0}, in=200, gold=0 twice → out_sse 40000 then 65535; sse_sat=1 and stays 1 until start.
5. rst_n pulsed low mid-MAC → all outputs 0 asynchronously; coefficients read back 0 (coef={1,..} stimulus then yields out_filt 0); no out_valid.
6. coef_we during RUN → ignored: filter output unchanged; IN/FS: DW=16, coef=32767, in=32767, FRAC=0 → out_filt saturates to 32767.

Source files
------------

// File: rtl/fir_sse_stream.sv
// Streaming FIR filter with a running sum-of-squared-error check against a golden stream.
// Optional feature macro FIR_SSE_MAX_ERR_EN adds max_abs_err (peak |y - gold| this run).
module fir_sse_stream #(
   parameter int DW    = 32,
   parameter int TAPS  = 8,
   parameter int FRAC  = 0,
   parameter int ACC_W = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [DW-1:0]           coef_data,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DW-1:0]           in_data,
   input  logic [DW-1:0]           gold_data,
   output logic                    out_valid,
   output logic [DW-1:0]           out_filt,
   output logic [ACC_W-1:0]        out_sse,
   output logic                    sse_sat,
   output logic [31:0]             sample_cnt,
   output logic                    busy,
   output logic                    done
`ifdef FIR_SSE_MAX_ERR_EN
   ,output logic [DW:0]            max_abs_err
`endif
);
   localparam int KW = $clog2(TAPS);
   localparam int AW = 2*DW + KW;
   localparam int PW = 2*DW + 2;
   localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
   localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, RUN, MAC, EVAL, DONE} state_t;
   state_t state_q, state_d;

   logic signed [DW-1:0] coef_q [TAPS];
   logic signed [DW-1:0] x_q    [TAPS];
   logic signed [DW-1:0] gold_q;
   logic signed [AW-1:0] acc_q;
   logic [KW-1:0]        k_q;
   logic                 stop_q;
   logic                 out_valid_q, sse_sat_q, done_q;
   logic [DW-1:0]        out_filt_q;
   logic [ACC_W-1:0]     out_sse_q;
   logic [31:0]          cnt_q;
`ifdef FIR_SSE_MAX_ERR_EN
   logic [DW:0]          maxe_q;
`endif

   logic signed [2*DW-1:0] cw, xw, prod;
   logic signed [AW-1:0]   sh;
   logic signed [DW-1:0]   y_d;
   logic signed [DW:0]     e_d;
   logic signed [PW-1:0]   ew, e2;
   logic [SW-1:0]          sum;
   logic                   ovf;
   logic [ACC_W-1:0]       sse_d;
   logic [DW:0]            ae;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RUN;
         RUN:        if (in_valid) state_d = MAC;
                     else if (stop) state_d = DONE;
         MAC:        if (k_q == KW'(TAPS-1)) state_d = EVAL;
         EVAL:       state_d = (stop_q || stop) ? DONE : RUN;
         default:    state_d = IDLE;
      endcase
   end

   // Operands widened before the multiply so the product is exact at 2*DW bits.
   always_comb begin
      cw   = {{DW{coef_q[k_q][DW-1]}}, coef_q[k_q]};
      xw   = {{DW{x_q[k_q][DW-1]}}, x_q[k_q]};
      prod = cw * xw;
      sh   = acc_q >>> FRAC;
      if (sh > YMAX)      y_d = YMAX[DW-1:0];
      else if (sh < YMIN) y_d = YMIN[DW-1:0];
      else                y_d = sh[DW-1:0];
      e_d  = {y_d[DW-1], y_d} - {gold_q[DW-1], gold_q};
      ew   = {{(PW-DW-1){e_d[DW]}}, e_d};
      e2   = ew * ew;
      sum  = {{(SW-ACC_W){1'b0}}, out_sse_q} + {{(SW-PW){1'b0}}, e2};
      ovf  = |sum[SW-1:ACC_W];
      sse_d = ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      ae   = e_d[DW] ? -e_d : e_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
            x_q[i]    <= '0;
         end
         gold_q      <= '0;
         acc_q       <= '0;
         k_q         <= '0;
         stop_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_filt_q  <= '0;
         out_sse_q   <= '0;
         sse_sat_q   <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
`ifdef FIR_SSE_MAX_ERR_EN
         maxe_q      <= '0;
`endif
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (coef_we && int'(coef_addr) < TAPS) coef_q[coef_addr] <= coef_data;
               if (start) begin
                  for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
                  out_sse_q <= '0;
                  sse_sat_q <= 1'b0;
                  cnt_q     <= '0;
                  done_q    <= 1'b0;
                  stop_q    <= 1'b0;
`ifdef FIR_SSE_MAX_ERR_EN
                  maxe_q    <= '0;
`endif
               end
            end
            RUN: if (in_valid) begin
               for (int i = TAPS-1; i > 0; i--) x_q[i] <= x_q[i-1];
               x_q[0] <= in_data;
               gold_q <= gold_data;
               acc_q  <= '0;
               k_q    <= '0;
               stop_q <= stop;
            end
            MAC: begin
               acc_q <= acc_q + {{KW{prod[2*DW-1]}}, prod};
               k_q   <= k_q + KW'(1);
               if (stop) stop_q <= 1'b1;
            end
            EVAL: begin
               out_filt_q  <= y_d;
               out_sse_q   <= sse_d;
               if (ovf) sse_sat_q <= 1'b1;
               cnt_q       <= cnt_q + 32'd1;
               out_valid_q <= 1'b1;
`ifdef FIR_SSE_MAX_ERR_EN
               if (ae > maxe_q) maxe_q <= ae;
`endif
            end
            default: ;
         endcase
         if (state_d == DONE && state_q != DONE) done_q <= 1'b1;
      end
   end

   assign in_ready   = (state_q == RUN);
   assign busy       = (state_q == MAC) || (state_q == EVAL);
   assign out_valid  = out_valid_q;
   assign out_filt   = out_filt_q;
   assign out_sse    = out_sse_q;
   assign sse_sat    = sse_sat_q;
   assign sample_cnt = cnt_q;
   assign done       = done_q;
`ifdef FIR_SSE_MAX_ERR_EN
   assign max_abs_err = maxe_q;
`else
   logic unused_ae;
   assign unused_ae = ^ae;
`endif

endmodule

// File: tb/tb_fir_sse_stream.sv
// Scoreboard bench for fir_sse_stream: two instances (A: DW16/TAPS4/ACC16, B: DW32/TAPS3/FRAC1).
module tb_fir_sse_stream;
   localparam int ATAPS = 4;
   localparam int BTAPS = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        a_coef_we, a_start, a_stop, a_in_valid;
   logic [1:0]  a_coef_addr;
   logic [15:0] a_coef_data, a_in_data, a_gold;
   logic        a_in_ready, a_out_valid, a_sse_sat, a_busy, a_done;
   logic [15:0] a_out_filt, a_out_sse;
   logic [31:0] a_cnt;

   logic        b_coef_we, b_start, b_stop, b_in_valid;
   logic [1:0]  b_coef_addr;
   logic [31:0] b_coef_data, b_in_data, b_gold;
   logic        b_in_ready, b_out_valid, b_sse_sat, b_busy, b_done;
   logic [31:0] b_out_filt;
   logic [63:0] b_out_sse;
   logic [31:0] b_cnt;
`ifdef FIR_SSE_MAX_ERR_EN
   logic [16:0] a_maxe;
   logic [32:0] b_maxe;
`endif

   fir_sse_stream #(.DW(16), .TAPS(ATAPS), .FRAC(0), .ACC_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
      .coef_data(a_coef_data), .start(a_start), .stop(a_stop), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .in_data(a_in_data), .gold_data(a_gold),
      .out_valid(a_out_valid), .out_filt(a_out_filt), .out_sse(a_out_sse),
      .sse_sat(a_sse_sat), .sample_cnt(a_cnt), .busy(a_busy), .done(a_done)
`ifdef FIR_SSE_MAX_ERR_EN
      , .max_abs_err(a_maxe)
`endif
   );

   fir_sse_stream #(.DW(32), .TAPS(BTAPS), .FRAC(1), .ACC_W(64)) u_b (
      .clk(clk), .rst_n(rst_n), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
      .coef_data(b_coef_data), .start(b_start), .stop(b_stop), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_data(b_in_data), .gold_data(b_gold),
      .out_valid(b_out_valid), .out_filt(b_out_filt), .out_sse(b_out_sse),
      .sse_sat(b_sse_sat), .sample_cnt(b_cnt), .busy(b_busy), .done(b_done)
`ifdef FIR_SSE_MAX_ERR_EN
      , .max_abs_err(b_maxe)
`endif
   );

   typedef struct {
      longint filt;
      longint sse;
      longint cnt;
      longint sat;
      longint due;
   } exp_t;
   exp_t qa[$];
   exp_t qb[$];

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n === 1'b1 && a_out_valid === 1'b1) begin
         if (qa.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL A spurious out_valid at cycle %0d: got 1, expected 0", cyc);
         end else begin
            e = qa.pop_front();
            chk("A out_filt", longint'($signed(a_out_filt)), e.filt);
            chk("A out_sse", longint'(a_out_sse), e.sse);
            chk("A sample_cnt", longint'(a_cnt), e.cnt);
            chk("A sse_sat", longint'(a_sse_sat), e.sat);
            chk("A latency cycle", longint'(cyc), e.due);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n === 1'b1 && b_out_valid === 1'b1) begin
         if (qb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL B spurious out_valid at cycle %0d: got 1, expected 0", cyc);
         end else begin
            e = qb.pop_front();
            chk("B out_filt", longint'($signed(b_out_filt)), e.filt);
            chk("B out_sse", longint'(b_out_sse), e.sse);
            chk("B sample_cnt", longint'(b_cnt), e.cnt);
            chk("B sse_sat", longint'(b_sse_sat), e.sat);
            chk("B latency cycle", longint'(cyc), e.due);
         end
      end
   end

   task automatic wcoef(input bit b, input int addr, input longint d);
      @(negedge clk);
      if (b) begin b_coef_we = 1'b1; b_coef_addr = addr[1:0]; b_coef_data = d[31:0]; end
      else   begin a_coef_we = 1'b1; a_coef_addr = addr[1:0]; a_coef_data = d[15:0]; end
      @(negedge clk);
      a_coef_we = 1'b0;
      b_coef_we = 1'b0;
   endtask

   task automatic do_start(input bit b);
      @(negedge clk);
      if (b) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic pulse_stop(input bit b);
      @(negedge clk);
      if (b) b_stop = 1'b1; else a_stop = 1'b1;
      @(negedge clk);
      a_stop = 1'b0;
      b_stop = 1'b0;
   endtask

   // Presents one sample, pushes its expected result, returns one cycle after the accept.
   task automatic send(input bit b, input longint din, input longint g, input bit want,
                       input longint ef, input longint es, input longint ec, input longint esat);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!(b ? b_in_ready : a_in_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         nchk++; nerr++;
         $display("FAIL %s in_ready timeout: got 0, expected 1", b ? "B" : "A");
      end
      if (b) begin b_in_valid = 1'b1; b_in_data = din[31:0]; b_gold = g[31:0]; end
      else   begin a_in_valid = 1'b1; a_in_data = din[15:0]; a_gold = g[15:0]; end
      if (want) begin
         e.filt = ef; e.sse = es; e.cnt = ec; e.sat = esat;
         e.due  = longint'(cyc) + 2 + (b ? BTAPS : ATAPS);
         if (b) qb.push_back(e); else qa.push_back(e);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0 || a_busy || b_busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         nchk++; nerr++;
         $display("FAIL drain timeout: got %0d pending, expected 0", qa.size() + qb.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      a_coef_we = 0; a_start = 0; a_stop = 0; a_in_valid = 0;
      a_coef_addr = '0; a_coef_data = '0; a_in_data = '0; a_gold = '0;
      b_coef_we = 0; b_start = 0; b_stop = 0; b_in_valid = 0;
      b_coef_addr = '0; b_coef_data = '0; b_in_data = '0; b_gold = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset A out_filt", longint'(a_out_filt), 0);
      chk("reset A out_sse", longint'(a_out_sse), 0);
      chk("reset A sample_cnt", longint'(a_cnt), 0);
      chk("reset A ready/busy/done/valid", longint'({a_in_ready, a_busy, a_done, a_out_valid, a_sse_sat}), 0);
      chk("reset B ready/busy/done/valid", longint'({b_in_ready, b_busy, b_done, b_out_valid, b_sse_sat}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // B: TAPS=3, FRAC=1, coef all 1 -> arithmetic shift including negative rounding
      for (int i = 0; i < BTAPS; i++) wcoef(1, i, 1);
      do_start(1);
      send(1,  3, 0, 1,  1,  1, 1, 0);
      send(1,  5, 0, 1,  4, 17, 2, 0);
      send(1, -7, 0, 1,  0, 17, 3, 0);
      send(1, -7, 0, 1, -5, 42, 4, 0);
      drain();

      // T1: identity filter, out == gold
      wcoef(0, 0, 1); wcoef(0, 1, 0); wcoef(0, 2, 0); wcoef(0, 3, 0);
      chk("A in_ready idle", longint'(a_in_ready), 0);
      do_start(0);
      chk("A in_ready run", longint'(a_in_ready), 1);
      send(0,  5,  5, 1,  5, 0, 1, 0);
      send(0, -3, -3, 1, -3, 0, 2, 0);
      send(0,  7,  7, 1,  7, 0, 3, 0);
      drain();

      // T2: moving sum of 4, gold 0
      pulse_stop(0);
      chk("A done after stop in RUN", longint'(a_done), 1);
      chk("A in_ready in DONE", longint'(a_in_ready), 0);
      for (int i = 0; i < ATAPS; i++) wcoef(0, i, 1);
      do_start(0);
      chk("A done cleared by start", longint'(a_done), 0);
      chk("A cnt cleared by start", longint'(a_cnt), 0);
      send(0, 1, 0, 1,  1,   1, 1, 0);
      send(0, 2, 0, 1,  3,  10, 2, 0);
      send(0, 3, 0, 1,  6,  46, 3, 0);
      send(0, 4, 0, 1, 10, 146, 4, 0);
      send(0, 5, 0, 1, 14, 342, 5, 0);
      drain();

      // T3: stop during MAC of the 2nd sample
      pulse_stop(0);
      do_start(0);
      send(0, 1, 0, 1, 1,  1, 1, 0);
      send(0, 2, 0, 1, 3, 10, 2, 0);
      a_stop = 1'b1;
      @(negedge clk);
      a_stop = 1'b0;
      drain();
      chk("A done after stop in MAC", longint'(a_done), 1);
      chk("A in_ready after stop in MAC", longint'(a_in_ready), 0);
      chk("A busy in DONE", longint'(a_busy), 0);
      chk("A cnt in DONE", longint'(a_cnt), 2);
      do_start(0);
      chk("A sse cleared by start", longint'(a_out_sse), 0);
      chk("A cnt cleared by start 2", longint'(a_cnt), 0);

      // T4: ACC_W=16 SSE saturation, sticky flag
      pulse_stop(0);
      wcoef(0, 0, 1); wcoef(0, 1, 0); wcoef(0, 2, 0); wcoef(0, 3, 0);
      do_start(0);
      send(0, 200, 0, 1, 200, 40000, 1, 0);
      send(0, 200, 0, 1, 200, 65535, 2, 1);
      drain();
      chk("A sse_sat sticky in RUN", longint'(a_sse_sat), 1);
      pulse_stop(0);
      chk("A sse_sat sticky in DONE", longint'(a_sse_sat), 1);
      do_start(0);
      chk("A sse_sat cleared by start", longint'(a_sse_sat), 0);

      // T6: coef write during RUN ignored; output saturation both ways
      send(0, 4, 4, 1, 4, 0, 1, 0);
      wcoef(0, 0, 5);
      send(0, 6, 0, 1, 6, 36, 2, 0);
      drain();
      pulse_stop(0);
      wcoef(0, 0, 32767);
      do_start(0);
      send(0,  32767, 0, 1,  32767, 65535, 1, 1);
      send(0, -32768, 0, 1, -32768, 65535, 2, 1);
      drain();

      // T5: async reset in the middle of MAC
      send(0, 9, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst A out_filt", longint'(a_out_filt), 0);
      chk("async rst A out_sse", longint'(a_out_sse), 0);
      chk("async rst A sample_cnt", longint'(a_cnt), 0);
      chk("async rst A busy/sat/ready", longint'({a_busy, a_sse_sat, a_in_ready, a_out_valid}), 0);
      #4 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("A no out_valid after reset", longint'(a_out_valid), 0);
      do_start(0);
      send(0, 9, 0, 1, 0, 0, 1, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
